// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul tile: FSM states, the k_len
// width function and the saturating-add helpers used by each PE.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of a counter able to hold 0..max_depth inclusive.
  function automatic int klen_width(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  // Signed add clamped to a w-bit two's complement range. Operands arrive
  // already sign-extended to 64 bits; w must stay below 63 so the raw sum
  // cannot overflow the longint.
  function automatic longint sat_add_signed(input longint a, input longint b,
                                            input int w);
    longint sum;
    longint hi;
    longint lo;
    sum = a + b;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

  // Unsigned add clamped to [0, 2^w-1]. Operands arrive zero-extended.
  function automatic longint sat_add_unsigned(input longint a, input longint b,
                                              input int w);
    longint sum;
    longint hi;
    sum = a + b;
    hi  = (longint'(1) <<< w) - 1;
    if (sum > hi) return hi;
    return sum;
  endfunction

endpackage

// File: rtl/matmul_pe.sv
// One multiply-accumulate cell of the output-stationary tile. The product
// is sign- or zero-extended per signed_mode, then either wrapped or clamped
// into the PsumWidth accumulator.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int PsumWidth = 16,
  parameter int Saturate  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic                 signed_mode,
  input  logic                 en,
  input  logic                 clr,
  output logic [PsumWidth-1:0] acc
);

  localparam int ProdWidth = 2 * DataWidth;

  logic signed [ProdWidth-1:0] prod_s;
  logic        [ProdWidth-1:0] prod_u;
  longint                      prod;
  longint                      sat_sum;
  logic        [PsumWidth-1:0] acc_next;

  // Next accumulator value: extended product added with wrap or clamp.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred even if the branches below are later reworked.
    prod_s   = ProdWidth'($signed(a)) * ProdWidth'($signed(b));
    prod_u   = ProdWidth'(a) * ProdWidth'(b);
    prod     = signed_mode ? longint'(prod_s) : longint'(prod_u);
    sat_sum  = 0;
    acc_next = acc + PsumWidth'(prod);
    if (Saturate != 0) begin
      if (signed_mode) begin
        sat_sum = sat_add_signed(longint'($signed(acc)), prod, PsumWidth);
      end else begin
        sat_sum = sat_add_unsigned(longint'(acc), prod, PsumWidth);
      end
      acc_next = PsumWidth'(sat_sum);
    end
  end

  // Accumulator register: cleared at tile start, updated on each accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      // NOTE: the accumulators are ordinary flops, not a RAM array, so they
      // can and do take the asynchronous reset to a known zero.
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_tile.sv
// Output-stationary Rows x Cols matrix-multiply tile. Streams K operand
// slices in over valid/ready, accumulates C = A x B in a PE grid, then
// drains C one row per handshake under downstream backpressure.
module matmul_tile
  import matmul_pkg::*;
#(
  parameter int  Rows      = 4,
  parameter int  Cols      = 4,
  parameter int  MaxDepth  = 9,
  parameter int  DataWidth = 8,
  parameter int  PsumWidth = 16,
  parameter int  Saturate  = 0,
  localparam int KlenWidth = klen_width(MaxDepth)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KlenWidth-1:0]      k_len,
  input  logic                      signed_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Rows*DataWidth-1:0] a_col,
  input  logic [Cols*DataWidth-1:0] b_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Cols*PsumWidth-1:0] out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int                  RowWidth = (Rows > 1) ? $clog2(Rows) : 1;
  localparam logic [RowWidth-1:0] LastRow  = RowWidth'(Rows - 1);
  localparam logic [KlenWidth-1:0] DepthMax = KlenWidth'(MaxDepth);

  state_t                 state;
  logic [KlenWidth-1:0]   k_lim;
  logic [KlenWidth-1:0]   k_cnt;
  logic [KlenWidth-1:0]   k_clamped;
  logic [RowWidth-1:0]    row;
  logic                   mode;
  logic                   accept_start;
  logic                   beat;
  logic [PsumWidth-1:0]   acc [Rows][Cols];

  assign accept_start = start && (state == IDLE);
  assign beat         = in_valid && in_ready;
  assign k_clamped    = (k_len > DepthMax) ? DepthMax : k_len;

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k_lim     <= '0;
      k_cnt     <= '0;
      row       <= '0;
      mode      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_lim <= k_clamped;
            mode  <= signed_mode;
            k_cnt <= '0;
            row   <= '0;
            busy  <= 1'b1;
            if (k_clamped == '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_last  <= (LastRow == '0);
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            if (k_cnt == k_lim - KlenWidth'(1)) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= (LastRow == '0);
              row       <= '0;
            end else begin
              k_cnt <= k_cnt + KlenWidth'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row == LastRow) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              row      <= row + RowWidth'(1);
              out_last <= (row + RowWidth'(1) == LastRow);
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // PE grid: A element r is shared along row r, B element c along column c.
  for (genvar r = 0; r < Rows; r++) begin : g_row
    for (genvar c = 0; c < Cols; c++) begin : g_col
      matmul_pe #(
        .DataWidth(DataWidth),
        .PsumWidth(PsumWidth),
        .Saturate (Saturate)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .a          (a_col[r*DataWidth +: DataWidth]),
        .b          (b_row[c*DataWidth +: DataWidth]),
        .signed_mode(mode),
        .en         (beat),
        .clr        (accept_start),
        .acc        (acc[r][c])
      );
    end
  end

  // Output mux: present the current drain row, zero when nothing is offered.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < Cols; c++) begin
        out_data[c*PsumWidth +: PsumWidth] = acc[row][c];
      end
    end
  end

endmodule

// File: tb/tb_matmul_tile.sv
// Self-checking bench for matmul_tile. Two instances (wrapping and
// saturating) share one stimulus stream; a reference model pushes the
// expected rows of each into scoreboard queues that drain handshakes pop.
module tb_matmul_tile;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEPTH = 9;
  localparam int DW    = 8;
  localparam int PW    = 16;
  localparam int KW    = 4;

  typedef logic [COLS*PW-1:0] row_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              signed_mode = 1'b0;
  logic              in_valid = 1'b0;
  logic [ROWS*DW-1:0] a_col = '0;
  logic [COLS*DW-1:0] b_row = '0;
  logic              out_ready = 1'b0;

  logic in_ready_w, out_valid_w, out_last_w, busy_w, done_w;
  logic in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
  row_t out_data_w, out_data_s;
  logic [4:0] ctrl_w, ctrl_s;

  assign ctrl_w = {in_ready_w, out_valid_w, out_last_w, busy_w, done_w};
  assign ctrl_s = {in_ready_s, out_valid_s, out_last_s, busy_s, done_s};

  matmul_tile #(
    .Rows(ROWS), .Cols(COLS), .MaxDepth(DEPTH),
    .DataWidth(DW), .PsumWidth(PW), .Saturate(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .out_last(out_last_w),
    .busy(busy_w), .done(done_w)
  );

  matmul_tile #(
    .Rows(ROWS), .Cols(COLS), .MaxDepth(DEPTH),
    .DataWidth(DW), .PsumWidth(PW), .Saturate(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_last(out_last_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  int   tests  = 0;
  int   failed = 0;
  row_t exp_w[$];
  row_t exp_s[$];
  int   a_m [ROWS][DEPTH];
  int   b_m [DEPTH][COLS];

  // Operand value as a 64-bit integer under the requested signedness.
  function automatic longint ext(input int v, input bit s);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return s ? longint'($signed(t)) : longint'(t);
  endfunction

  task automatic fill_const(input int av, input int bv);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < DEPTH; k++) a_m[r][k] = av;
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = bv;
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < DEPTH; k++) a_m[r][k] = int'($urandom_range(255));
    for (int k = 0; k < DEPTH; k++)
      for (int c = 0; c < COLS; c++) b_m[k][c] = int'($urandom_range(255));
  endtask

  // Reference model: one expected row per C row for each instance.
  task automatic push_expected(input int keff, input bit sm);
    row_t   rw, rs;
    longint aw, as, p;
    for (int r = 0; r < ROWS; r++) begin
      rw = '0;
      rs = '0;
      for (int c = 0; c < COLS; c++) begin
        aw = 0;
        as = 0;
        for (int k = 0; k < keff; k++) begin
          p  = ext(a_m[r][k], sm) * ext(b_m[k][c], sm);
          aw = (aw + p) & 64'hFFFF;
          as = as + p;
          if (sm) begin
            if (as > 32767) as = 32767;
            if (as < -32768) as = -32768;
          end else if (as > 65535) begin
            as = 65535;
          end
        end
        rw[c*PW +: PW] = aw[PW-1:0];
        rs[c*PW +: PW] = as[PW-1:0];
      end
      exp_w.push_back(rw);
      exp_s.push_back(rs);
    end
  endtask

  // Pulse start (with junk on the ignored in_valid) and check the response.
  task automatic do_start(input int kl, input bit sm, output int keff);
    logic [4:0] ec;
    keff = (kl > DEPTH) ? DEPTH : kl;
    push_expected(keff, sm);
    start       = 1'b1;
    k_len       = kl[KW-1:0];
    signed_mode = sm;
    in_valid    = 1'b1;
    a_col       = $urandom;
    b_row       = $urandom;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    ec = {keff > 0, keff == 0, 1'b0, 1'b1, 1'b0};
    tests++;
    if (ctrl_w !== ec || ctrl_s !== ec) begin
      failed++;
      $display("FAIL start_ctrl k=%0d: got %b/%b want %b", kl, ctrl_w, ctrl_s, ec);
    end
  endtask

  // Stream keff k-slices with pct% in_valid duty; optionally spam start.
  task automatic feed(input int keff, input int pct, input bit spam);
    int         beat = 0;
    int         budget = 0;
    int         tmp;
    bit         hs;
    logic [4:0] ec;
    while (beat < keff && budget < 400) begin
      in_valid = ($urandom_range(99) < pct);
      a_col    = $urandom;
      b_row    = $urandom;
      if (in_valid) begin
        for (int r = 0; r < ROWS; r++) begin
          tmp = a_m[r][beat];
          a_col[r*DW +: DW] = tmp[DW-1:0];
        end
        for (int c = 0; c < COLS; c++) begin
          tmp = b_m[beat][c];
          b_row[c*DW +: DW] = tmp[DW-1:0];
        end
      end
      start = spam;
      k_len = '0;
      if (spam) signed_mode = ~signed_mode;
      hs = in_valid && in_ready_w;
      @(posedge clk); #1;
      budget++;
      if (hs) beat++;
      ec = {beat < keff, beat == keff, 1'b0, 1'b1, 1'b0};
      tests++;
      if (ctrl_w !== ec || ctrl_s !== ec) begin
        failed++;
        $display("FAIL accum_ctrl beat=%0d: got %b/%b want %b", beat, ctrl_w, ctrl_s, ec);
      end
    end
    if (beat < keff) begin
      tests++;
      failed++;
      $display("FAIL feed_timeout: %0d of %0d beats taken", beat, keff);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Drain nrows rows, stalling out_ready on stall_row for stall_cyc cycles.
  task automatic drain(input int nrows, input int stall_row, input int stall_cyc,
                       input bit spam);
    int         row = 0;
    int         stalled = 0;
    int         budget = 0;
    bit         hs;
    logic [4:0] ec;
    while (row < nrows && budget < 200) begin
      out_ready = !(row == stall_row && stalled < stall_cyc);
      if (!out_ready) stalled++;
      in_valid = 1'b1;
      a_col    = $urandom;
      b_row    = $urandom;
      start    = spam;
      ec = {1'b0, 1'b1, row == ROWS - 1, 1'b1, 1'b0};
      tests++;
      if (ctrl_w !== ec || ctrl_s !== ec) begin
        failed++;
        $display("FAIL drain_ctrl row=%0d: got %b/%b want %b", row, ctrl_w, ctrl_s, ec);
      end
      tests++;
      if (exp_w.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty row=%0d", row);
      end else if (out_data_w !== exp_w[0] || out_data_s !== exp_s[0]) begin
        failed++;
        $display("FAIL row_data row=%0d: wrap %h want %h, sat %h want %h",
                 row, out_data_w, exp_w[0], out_data_s, exp_s[0]);
      end
      hs = out_valid_w && out_ready;
      @(posedge clk); #1;
      budget++;
      if (hs) begin
        void'(exp_w.pop_front());
        void'(exp_s.pop_front());
        row++;
      end
    end
    if (row < nrows) begin
      tests++;
      failed++;
      $display("FAIL drain_timeout: %0d of %0d rows taken", row, nrows);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Check the done pulse; unless chaining, also check it lasts one cycle.
  task automatic finish_tile(input bit chain);
    tests++;
    if (ctrl_w !== 5'b00001 || ctrl_s !== 5'b00001) begin
      failed++;
      $display("FAIL done_pulse: got %b/%b want 00001", ctrl_w, ctrl_s);
    end
    if (!chain) begin
      @(posedge clk); #1;
      tests++;
      if (ctrl_w !== 5'b00000 || ctrl_s !== 5'b00000) begin
        failed++;
        $display("FAIL idle_after_done: got %b/%b want 00000", ctrl_w, ctrl_s);
      end
    end
  endtask

  task automatic run_tile(input int kl, input bit sm, input int pct,
                          input int stall_row, input int stall_cyc,
                          input bit spam, input bit chain);
    int keff;
    do_start(kl, sm, keff);
    feed(keff, pct, spam);
    drain(ROWS, stall_row, stall_cyc, spam);
    finish_tile(chain);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (ctrl_w !== 5'b0 || ctrl_s !== 5'b0 || out_data_w !== '0 || out_data_s !== '0) begin
      failed++;
      $display("FAIL reset_state: ctrl %b/%b data %h/%h want zeros",
               ctrl_w, ctrl_s, out_data_w, out_data_s);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ctrl_w !== 5'b0 || ctrl_s !== 5'b0) begin
      failed++;
      $display("FAIL idle_after_reset: got %b/%b want 00000", ctrl_w, ctrl_s);
    end
  endtask

  task automatic test_basic_unsigned();
    fill_const(1, 2);
    run_tile(9, 1'b0, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    fill_random();
    a_m[0][0] = -1; a_m[0][1] = -2; a_m[0][2] = 3;
    b_m[0][0] = 4;  b_m[1][0] = 5;  b_m[2][0] = -6;
    run_tile(3, 1'b1, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    fill_const(127, 127);
    run_tile(9, 1'b1, 100, -1, 0, 1'b0, 1'b0);
    fill_const(-128, 127);
    run_tile(9, 1'b1, 100, -1, 0, 1'b0, 1'b0);
    fill_const(255, 255);
    run_tile(9, 1'b0, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random_valid();
    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_tile(int'($urandom_range(1, DEPTH)), 1'($urandom_range(1)), 50,
               -1, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_tile(9, 1'b0, 100, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_k_zero();
    fill_random();
    run_tile(0, 1'b1, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_k_clamp();
    fill_random();
    run_tile(15, 1'b1, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_tile(6, 1'b0, 70, -1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_tile(4, 1'b1, 100, -1, 0, 1'b0, 1'b1);
    fill_random();
    run_tile(5, 1'b0, 100, 2, 2, 1'b0, 1'b1);
    fill_random();
    run_tile(2, 1'b0, 100, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    int keff;
    fill_random();
    do_start(9, 1'b0, keff);
    feed(keff, 100, 1'b0);
    drain(2, -1, 0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (ctrl_w !== 5'b0 || ctrl_s !== 5'b0 || out_data_w !== '0 || out_data_s !== '0) begin
      failed++;
      $display("FAIL async_reset: ctrl %b/%b data %h/%h want zeros",
               ctrl_w, ctrl_s, out_data_w, out_data_s);
    end
    exp_w.delete();
    exp_s.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ctrl_w !== 5'b0 || ctrl_s !== 5'b0) begin
      failed++;
      $display("FAIL no_done_after_reset: got %b/%b want 00000", ctrl_w, ctrl_s);
    end
    fill_random();
    run_tile(9, 1'b1, 100, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_unsigned();
    test_signed();
    test_saturation();
    test_random_valid();
    test_backpressure();
    test_k_zero();
    test_k_clamp();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/matmul_tile.md
# matmul_tile

Parametrised output-stationary matrix-multiply tile computing C[Rows][Cols] = A[Rows][K] × B[K][Cols] for a runtime reduction length K ≤ MaxDepth. Successor to the fixed-size matrix-multiply top. It adds:

- start/done control;
- streamed operand input with valid/ready;
- signed/unsigned mode;
- optional saturation;
- row-by-row drain of the result tile under backpressure.

It sits between the operand buffers (activation/weight SRAM readers) and the psum writeback path.

## Interface
- Rows, 4, PE rows (A rows / C rows)
- Cols, 4, PE columns (B columns / C columns)
- MaxDepth, 9, maximum reduction length K
- DataWidth, 8, operand width
- PsumWidth, 16, accumulator/output element width; must be ≥ 2*DataWidth
- Saturate, 0, 0 = wrap on accumulate overflow, 1 = clamp to PsumWidth range
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a tile; accepted only in IDLE
- k_len  in  $clog2(MaxDepth+1)  reduction length, sampled on accepted start
- signed_mode  in  1  1 = operands and psums two's complement; sampled on accepted start
- in_valid  in  1  k-slice present
- in_ready  out  1  tile accepts a k-slice
- a_col  in  Rows*DataWidth  A[r][k] for all r; row 0 in LSBs
- b_row  in  Cols*DataWidth  B[k][c] for all c; column 0 in LSBs
- out_valid  out  1  result row present
- out_ready  in  1  downstream accepts result row
- out_data  out  Cols*PsumWidth  C[r][c] for current row r; column 0 in LSBs
- out_last  out  1  out_data is row Rows-1
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after final row handshake

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1 latches k_len (clamped to MaxDepth) and signed_mode, and clears all Rows*Cols accumulators.
  - Next state is ACCUM, or DRAIN if the latched k_len is 0.
- ACCUM:
  - in_ready=1.
  - Each in_valid&in_ready beat updates every PE: acc[r][c] += a[r]*b[c].
  - The product is 2*DataWidth wide, sign- or zero-extended per signed_mode to PsumWidth.
  - The k counter increments per beat. The beat where k = k_len-1 moves the FSM to DRAIN.
- DRAIN:
  - out_valid=1 and out_data = acc[row].
  - The row counter advances on each out_valid&out_ready beat.
  - out_last=1 when row = Rows-1.
  - The handshake on the last row moves the FSM to IDLE with done=1 for one cycle.
- Saturate=1:
  - signed: clamp to [-2^(PsumWidth-1), 2^(PsumWidth-1)-1];
  - unsigned: clamp to [0, 2^PsumWidth-1].
  - Clamping applies per accumulate step.
- Saturate=0: modulo 2^PsumWidth.
- start outside IDLE is ignored and has no side effects.
- in_valid outside ACCUM is ignored; no accumulate occurs.
- out_data holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - in_ready=0, out_valid=0, out_last=0, busy=0, done=0;
  - out_data=0;
  - all accumulators and counters = 0.
- Reset mid-tile aborts immediately. No done pulse.
- busy and in_ready rise the cycle after the accepted start.
- MAC latency 1 cycle: acc is visible at the next edge after the beat.
- out_valid rises the cycle after the last input beat (or after start when k_len=0).
- Minimum tile time with no stalls: 1 (start) + K + Rows cycles; done is in the cycle after the last drain beat.
- done and start may coincide: a start in the cycle done=1 is accepted, because the FSM is already IDLE.
- in_ready and out_valid are never high together.

## Structure
- Package matmul_pkg holds:
  - state enum (IDLE/ACCUM/DRAIN);
  - saturation helper functions (sat_add signed/unsigned);
  - the k_len width localparam function.
- Sub-module matmul_pe: one MAC cell with in a, b, signed_mode, en, clr, and out acc[PsumWidth]. The tile instantiates Rows×Cols of it via generate.
- Top holds the FSM, the k/row counters and the output mux.

## Test plan
- **Basic unsigned:** defaults, Saturate=0, K=9, all a=1, b=2 → 4 rows each with every element 0x0012, out_last on row 3, done 1 cycle after.
- **Signed:** signed_mode=1, K=3, a[0]={-1,-2,3}, b[0]={4,5,-6} → C[0][0] = -4-10-18 = -32 = 0xFFE0.
- **Saturation:**
  - Saturate=1, signed, K=9, a=127, b=127 → C = 0x7FFF rather than the wrapped value;
  - unsigned, a=b=255 → 0xFFFF.
- **Backpressure / stalls:**
  - in_valid random 50% → identical results;
  - out_ready low for 5 cycles on row 1 → out_data stable, no row skipped.
- **Boundaries:**
  - k_len=0 → 4 zero rows;
  - k_len=15 → clamped to 9 beats;
  - start during ACCUM → ignored.
- **Reset mid-DRAIN:** rst low at row 2 → all outputs 0 asynchronously, no done; next tile computes correctly from cleared accumulators.
